// File: rtl/ofdm_tx_pkg.sv
`default_nettype none
// ============================================================================
// ofdm_tx_pkg : shared constants and scheduler state encoding for OFDM Tx
// Revision    : 1.0
// ============================================================================
package ofdm_tx_pkg;

    localparam int SYM_W     = 224;
    localparam int SYM_BEATS = 225;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_PRE = 3'd1,
        FETCH_PAY = 3'd2,
        WRITE     = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5,
        GAP       = 3'd6
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/ofdm_tx_drain_ctr.sv
`default_nettype none
// ============================================================================
// ofdm_tx_drain_ctr : up-counter with clear/enable, saturating at 'term'
// Revision          : 1.0
// ============================================================================
module ofdm_tx_drain_ctr
    import ofdm_tx_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc
);

    logic [CNT_W-1:0] r_cnt;

    // Holding at 'term' keeps a stray extra enable from wrapping the count.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != term)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tc = (r_cnt == term);

endmodule
`default_nettype wire

// File: rtl/ofdm_tx_sym_sched.sv
`default_nettype none
// ============================================================================
// ofdm_tx_sym_sched : frame scheduler feeding preamble/payload symbols into the
//                     Tx serial buffer. Optional inter-frame gap: TX_SCHED_GUARD_GAP_EN
// Revision          : 1.0
// ============================================================================
module ofdm_tx_sym_sched
    import ofdm_tx_pkg::*;
#(
    parameter int NUM_PRE    = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       pay_len,
    input  logic [SYM_W-1:0] pre_data,
    input  logic             pre_valid,
    output logic             pre_ready,
    input  logic [SYM_W-1:0] pay_data,
    input  logic             pay_valid,
    output logic             pay_ready,
    output logic [SYM_W-1:0] buf_din,
    output logic             buf_din_valid,
    input  logic             buf_din_wready,
    input  logic             buf_dout_valid,
    output logic             buf_dout_rready,
    output logic             busy,
    output logic [7:0]       sym_idx,
    output logic             frame_done
);

    localparam logic [3:0]       c_pre_last  = 4'(NUM_PRE - 1);
    localparam logic [CNT_W-1:0] c_beat_term = CNT_W'(SYM_BEATS - 1);
    localparam logic [CNT_W-1:0] c_gap_term  = CNT_W'(GAP_CYCLES - 1);

    sched_state_t     r_state;
    sched_state_t     w_next;
    logic [SYM_W-1:0] r_hold;
    logic [7:0]       r_len;
    logic [3:0]       r_pre_cnt;
    logic [7:0]       r_sym_idx;
    logic             r_in_pay;

    logic             w_ctr_clr;
    logic             w_ctr_en;
    logic [CNT_W-1:0] w_ctr_term;
    logic             w_ctr_tc;
    logic             w_last_beat;
    logic             w_pay_more;

    ofdm_tx_drain_ctr u_drain_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (w_ctr_clr),
        .en    (w_ctr_en),
        .term  (w_ctr_term),
        .tc    (w_ctr_tc)
    );

    assign w_last_beat = (r_state == DRAIN) && buf_dout_valid && w_ctr_tc;
    // Widened so that len_q = 255 still yields 255 payload symbols.
    assign w_pay_more  = ({1'b0, r_sym_idx} + 9'd1) < {1'b0, r_len};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        pre_ready       = 1'b0;
        pay_ready       = 1'b0;
        buf_din_valid   = 1'b0;
        buf_dout_rready = 1'b0;
        frame_done      = 1'b0;
        busy            = 1'b1;
        w_ctr_clr       = 1'b1;
        w_ctr_en        = 1'b0;
        w_ctr_term      = c_beat_term;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = FETCH_PRE;
                end
            end
            FETCH_PRE: begin
                pre_ready = 1'b1;
                if (pre_valid) begin
                    w_next = WRITE;
                end
            end
            FETCH_PAY: begin
                pay_ready = 1'b1;
                if (pay_valid) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                buf_din_valid = 1'b1;
                if (buf_din_wready) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                buf_dout_rready = 1'b1;
                w_ctr_clr       = 1'b0;
                w_ctr_en        = buf_dout_valid;
                if (w_last_beat) begin
                    if (r_in_pay) begin
                        w_next = w_pay_more ? FETCH_PAY : DONE;
                    end else if (r_pre_cnt < c_pre_last) begin
                        w_next = FETCH_PRE;
                    end else if (r_len != 8'd0) begin
                        w_next = FETCH_PAY;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
`ifdef TX_SCHED_GUARD_GAP_EN
                w_next     = GAP;
`else
                w_next     = IDLE;
`endif
            end
            GAP: begin
                busy       = 1'b0;
                w_ctr_clr  = 1'b0;
                w_ctr_en   = 1'b1;
                w_ctr_term = c_gap_term;
                if (w_ctr_tc) begin
                    w_next = IDLE;
                end
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold    <= '0;
            r_len     <= '0;
            r_pre_cnt <= '0;
            r_sym_idx <= '0;
            r_in_pay  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len     <= pay_len;
                        r_pre_cnt <= '0;
                        r_sym_idx <= '0;
                        r_in_pay  <= 1'b0;
                    end
                end
                FETCH_PRE: begin
                    if (pre_valid) begin
                        r_hold <= pre_data;
                    end
                end
                FETCH_PAY: begin
                    if (pay_valid) begin
                        r_hold   <= pay_data;
                        r_in_pay <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_last_beat) begin
                        if (r_in_pay) begin
                            if (w_pay_more) begin
                                r_sym_idx <= r_sym_idx + 8'd1;
                            end
                        end else if (r_pre_cnt < c_pre_last) begin
                            r_pre_cnt <= r_pre_cnt + 4'd1;
                        end else begin
                            r_sym_idx <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign buf_din = r_hold;
    assign sym_idx = r_sym_idx;

endmodule
`default_nettype wire

// File: tb/tb_ofdm_tx_sym_sched.sv
`default_nettype none
// Scoreboard bench for ofdm_tx_sym_sched: stimulus pushes expected words/frames,
// a negedge monitor pops and compares.
module tb_ofdm_tx_sym_sched;

    localparam int NPRE  = 2;
    localparam int BEATS = 225;
`ifdef TX_SCHED_GUARD_GAP_EN
    localparam int RESTART_LAT = 18;
`else
    localparam int RESTART_LAT = 2;
`endif

    typedef struct {
        int nsym;
        int npay;
    } frame_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [7:0]   pay_len;
    logic [223:0] pre_data;
    logic         pre_valid;
    logic         pre_ready;
    logic [223:0] pay_data;
    logic         pay_valid;
    logic         pay_ready;
    logic [223:0] buf_din;
    logic         buf_din_valid;
    logic         buf_din_wready;
    logic         buf_dout_valid;
    logic         buf_dout_rready;
    logic         busy;
    logic [7:0]   sym_idx;
    logic         frame_done;

    always #5 clk = ~clk;

    ofdm_tx_sym_sched #(.NUM_PRE(2), .GAP_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .pay_len         (pay_len),
        .pre_data        (pre_data),
        .pre_valid       (pre_valid),
        .pre_ready       (pre_ready),
        .pay_data        (pay_data),
        .pay_valid       (pay_valid),
        .pay_ready       (pay_ready),
        .buf_din         (buf_din),
        .buf_din_valid   (buf_din_valid),
        .buf_din_wready  (buf_din_wready),
        .buf_dout_valid  (buf_dout_valid),
        .buf_dout_rready (buf_dout_rready),
        .busy            (busy),
        .sym_idx         (sym_idx),
        .frame_done      (frame_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [223:0] exp_words[$];
    frame_t       exp_frames[$];

    task automatic check(input bit ok, input string name,
                         input logic [223:0] act, input logic [223:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [223:0] mk_word(input int kind, input int k);
        logic [31:0] w;
        w = {8'(kind), 8'(k), 8'(k * 3 + 1), 8'(~k)};
        return {7{w}} ^ {192'd0, 32'(k)};
    endfunction

    // ---------------- stimulus side ----------------
    int  pre_i = 0;
    int  pay_i = 0;
    int  mbeats = 0;
    int  stall_cnt = 0;
    bit  stall_mode = 1'b0;
    bit  toggle_mode = 1'b0;
    bit  chk_restart = 1'b0;
    bit  smp_pre, smp_pay, smp_done, smp_beat;

    task automatic tick();
        @(negedge clk);
        smp_pre  = pre_valid && pre_ready;
        smp_pay  = pay_valid && pay_ready;
        smp_done = frame_done;
        smp_beat = buf_dout_valid && buf_dout_rready;
        if (buf_din_valid && !buf_din_wready) stall_cnt++;
        if (buf_din_valid && buf_din_wready) stall_cnt = 0;
        @(posedge clk);
        #2;
        if (smp_pre) pre_i++;
        if (smp_pay) pay_i++;
        if (smp_beat) mbeats++;
        pre_data       = mk_word(1, pre_i);
        pay_data       = mk_word(2, pay_i);
        buf_din_wready = stall_mode ? (stall_cnt >= 10) : 1'b1;
        buf_dout_valid = toggle_mode ? ~buf_dout_valid : 1'b1;
    endtask

    task automatic push_frame(input int len);
        frame_t f;
        for (int k = 0; k < NPRE; k++) exp_words.push_back(mk_word(1, pre_i + k));
        for (int k = 0; k < len; k++) exp_words.push_back(mk_word(2, pay_i + k));
        f.nsym = NPRE + len;
        f.npay = len;
        exp_frames.push_back(f);
    endtask

    task automatic wait_done(input int budget, input bit busy_pulse);
        int it;
        it = 0;
        smp_done = 1'b0;
        while (!smp_done && it < budget) begin
            if (busy_pulse && (it == 5 || it == 300 || it == 700)) begin
                start   = 1'b1;
                pay_len = 8'd7;
            end else begin
                start = 1'b0;
            end
            tick();
            it++;
        end
        start = 1'b0;
        check(smp_done, "frame_done_wait", 224'(it), 224'(budget));
    endtask

    task automatic run_frame(input int len, input bit busy_pulse);
        repeat (20) tick();
        push_frame(len);
        pay_len = 8'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        pay_len = 8'hAA;
        wait_done(8000, busy_pulse);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        pay_len        = 8'd0;
        pre_valid      = 1'b1;
        pay_valid      = 1'b1;
        pre_data       = mk_word(1, 0);
        pay_data       = mk_word(2, 0);
        buf_din_wready = 1'b1;
        buf_dout_valid = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        run_frame(3, 1'b0);
        run_frame(0, 1'b0);

        stall_mode  = 1'b1;
        toggle_mode = 1'b1;
        run_frame(2, 1'b1);
        stall_mode  = 1'b0;
        toggle_mode = 1'b0;

        // Reset part-way through the first drain of a frame.
        repeat (20) tick();
        push_frame(1);
        pay_len = 8'd1;
        start   = 1'b1;
        mbeats  = 0;
        tick();
        start = 1'b0;
        for (int it = 0; it < 1000 && mbeats < 100; it++) tick();
        check(mbeats == 100, "reach_beat_100", 224'(mbeats), 224'd100);
        reset = 1'b1;
        exp_words.delete();
        exp_frames.delete();
        tick();
        reset = 1'b0;
        repeat (5) tick();

        run_frame(2, 1'b0);

        // Back-to-back frames with start held high from the first legal cycle.
        run_frame(1, 1'b0);
        chk_restart = 1'b1;
        push_frame(1);
        pay_len = 8'd1;
        repeat (20) begin
            start = 1'b1;
            tick();
        end
        start = 1'b0;
        wait_done(8000, 1'b0);
        chk_restart = 1'b0;

        repeat (30) tick();
        check(exp_words.size() == 0, "words_left", 224'(exp_words.size()), 224'd0);
        check(exp_frames.size() == 0, "frames_left", 224'(exp_frames.size()), 224'd0);
        check(!busy, "final_idle", 224'(busy), 224'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- monitor / scoreboard ----------------
    int           cyc = 0;
    int           done_cyc = 0;
    int           beats = 0;
    int           drained = 0;
    int           npre = 0;
    int           npay = 0;
    bit           rst_seen = 1'b0;
    bit           prev_rr = 1'b0;
    bit           prev_last = 1'b0;
    bit           prev_stall = 1'b0;
    bit           prev_busy = 1'b0;
    bit           prev_done = 1'b0;
    logic [223:0] prev_din = '0;

    always @(negedge clk) begin
        logic [223:0] w;
        frame_t       f;
        cyc++;
        if (reset) begin
            rst_seen   = 1'b1;
            beats      = 0;
            drained    = 0;
            npre       = 0;
            npay       = 0;
            prev_rr    = 1'b0;
            prev_last  = 1'b0;
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (rst_seen) begin
                rst_seen = 1'b0;
                check(!busy, "rst_busy", 224'(busy), 224'd0);
                check(!buf_dout_rready, "rst_rready", 224'(buf_dout_rready), 224'd0);
                check(!frame_done, "rst_frame_done", 224'(frame_done), 224'd0);
                check(dut.u_drain_ctr.r_cnt == 8'd0, "rst_beat_cnt",
                      224'(dut.u_drain_ctr.r_cnt), 224'd0);
                check(!buf_din_valid && !pre_ready && !pay_ready && sym_idx == 8'd0,
                      "rst_outputs", {buf_din_valid, pre_ready, pay_ready, sym_idx}, 224'd0);
            end

            if (busy && !prev_busy) begin
                check(exp_frames.size() != 0, "start_accept", 224'(busy), 224'd0);
                if (chk_restart)
                    check(cyc - done_cyc == RESTART_LAT, "restart_latency",
                          224'(cyc - done_cyc), 224'(RESTART_LAT));
            end

            if (pre_valid && pre_ready) npre++;
            if (pay_valid && pay_ready) npay++;

            if (prev_stall)
                check(buf_din_valid && buf_din == prev_din, "write_hold", buf_din, prev_din);
            if (buf_din_valid && buf_din_wready) begin
                if (exp_words.size() == 0) begin
                    check(1'b0, "write_unexpected", buf_din, 224'd0);
                end else begin
                    w = exp_words.pop_front();
                    check(buf_din === w, "buf_din", buf_din, w);
                end
            end
            prev_stall = buf_din_valid && !buf_din_wready;
            prev_din   = buf_din;

            if (prev_last)
                check(!buf_dout_rready, "rready_fall", 224'(buf_dout_rready), 224'd0);
            if (prev_rr && !buf_dout_rready) begin
                check(beats == BEATS, "beats_per_sym", 224'(beats), 224'(BEATS));
                drained++;
                beats = 0;
            end

            if (frame_done) begin
                check(prev_last, "done_timing", 224'(prev_last), 224'd1);
                check(!prev_done, "done_width", 224'(prev_done), 224'd0);
                if (exp_frames.size() == 0) begin
                    check(1'b0, "done_unexpected", 224'(frame_done), 224'd0);
                end else begin
                    f = exp_frames.pop_front();
                    check(drained == f.nsym, "symbols_drained", 224'(drained), 224'(f.nsym));
                    check(npre == NPRE, "pre_ready_pulses", 224'(npre), 224'(NPRE));
                    check(npay == f.npay, "pay_ready_pulses", 224'(npay), 224'(f.npay));
                end
                drained  = 0;
                npre     = 0;
                npay     = 0;
                done_cyc = cyc;
            end

            if (buf_dout_valid && buf_dout_rready) begin
                beats++;
                prev_last = (beats == BEATS);
            end else begin
                prev_last = 1'b0;
            end
            prev_rr   = buf_dout_rready;
            prev_busy = busy;
            prev_done = frame_done;
        end
    end

endmodule
`default_nettype wire

// File: doc/ofdm_tx_sym_sched.md
Name: ofdm_tx_sym_sched

Overview:
Frame-level scheduler in front of the OFDM Tx serial input buffer. Each frame is NUM_PRE preamble symbols from the preamble source, then a run-time count of payload symbols from the payload source. Each symbol is one 224-bit word. The block latches one word at a time, writes it into the buffer, then paces the buffer's serial drain before loading the next word. It is the sole writer and sole drain-master of that buffer.

Parameters:
SYM_W, 224, symbol word width in bits; must match the buffer input width.
SYM_BEATS, 225, serial beats that drain one buffered word (dout_valid && dout_rready count).
NUM_PRE, 2, preamble symbols per frame (1..15).
GAP_CYCLES, 16, idle cycles between frames (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a frame (ignored unless IDLE)
pay_len  in  8  payload symbols in the frame, sampled at start; 0 = preamble only
pre_data  in  224  preamble word
pre_valid  in  1  preamble word available
pre_ready  out  1  preamble word taken this cycle
pay_data  in  224  payload word
pay_valid  in  1  payload word available
pay_ready  out  1  payload word taken this cycle
buf_din  out  224  word to buffer
buf_din_valid  out  1  buf_din valid
buf_din_wready  in  1  buffer accepted the word
buf_dout_valid  in  1  buffer serial output valid
buf_dout_rready  out  1  drain enable to buffer
busy  out  1  frame in progress
sym_idx  out  8  index of the current symbol within the payload (0 during preamble)
frame_done  out  1  one-cycle pulse when the last drain completes

Behaviour:
- Reset (synchronous, active-high) applies in any state, including mid-frame.
  - All outputs go to 0 and the FSM goes to IDLE.
  - The hold register clears; counters clear.
- FSM states:
  - IDLE: start moves to FETCH_PRE with pre_cnt=0. pay_len is latched as len_q.
  - FETCH_PRE / FETCH_PAY: ready = 1 for the matching source only. Ready is combinational: (state==FETCH_x).
    - When valid && ready, the word is latched into the hold register. Next state is WRITE.
    - Exactly one word is taken per symbol.
  - WRITE: buf_din_valid = 1 and buf_din = hold register, both stable until buf_din_valid && buf_din_wready. Then go to DRAIN and clear beat_cnt.
  - DRAIN: buf_dout_rready = 1. beat_cnt increments on each buf_dout_valid && buf_dout_rready.
    - When beat_cnt reaches SYM_BEATS-1 and a beat occurs, drop rready in the next cycle and advance.
    - Preamble advance: pre_cnt < NUM_PRE-1 goes to FETCH_PRE. Otherwise, if len_q != 0, go to FETCH_PAY with sym_idx=0; if len_q == 0, go to DONE.
    - Payload advance: sym_idx < len_q-1 increments sym_idx and goes to FETCH_PAY. Otherwise go to DONE.
  - DONE: frame_done = 1 for exactly one cycle, then IDLE (or GAP, see the optional feature).
- busy = 1 in every state except IDLE (and except GAP).
- start while busy is ignored and not queued.
- pay_len changes mid-frame have no effect.
- A source that drops valid while in FETCH stalls the FSM indefinitely; no timeout.
- Latency: at most 1 cycle from source handshake to buf_din_valid. At most 1 cycle from the final drain beat to the next FETCH.
- beat_cnt is 8 bits and saturates at SYM_BEATS-1; it never wraps.
- sym_idx is 8 bits; len_q = 255 is legal and gives 255 payload symbols.

Optional Feature:
Macro TX_SCHED_GUARD_GAP_EN.
- Defined: DONE goes to GAP, which holds for GAP_CYCLES cycles with all ready/valid outputs low and busy = 0. A start arriving in GAP is ignored. GAP then returns to IDLE.
- Undefined: DONE goes straight to IDLE, and start is accepted in the very next cycle.

Decomposition:
- Shared package ofdm_tx_pkg holds:
  - SYM_W and SYM_BEATS constants;
  - the state enum (IDLE, FETCH_PRE, FETCH_PAY, WRITE, DRAIN, DONE, GAP).
- One sub-module, ofdm_tx_drain_ctr: beat counter with clear, enable, and terminal-count output. It is used for DRAIN and reused for the GAP countdown.

Test Plan:
- Reset mid-DRAIN (beat 100): reset high one cycle → busy=0, buf_dout_rready=0, beat_cnt=0, no frame_done. Next start runs a full frame.
- start, pay_len=3, both sources always valid → exactly 2 pre_ready pulses, then 3 pay_ready pulses. Each buf_din matches its source word. frame_done appears once, 1 cycle after the 5th drain completes.
- pay_len=0 → 2 preamble symbols only, 0 pay_ready, frame_done after the 2nd drain.
- buf_din_wready held low 10 cycles in WRITE → buf_din and buf_din_valid stay stable; the FSM leaves WRITE on the wready cycle only.
- buf_dout_valid toggling 50% during DRAIN → exactly 225 counted beats per symbol; rready falls the cycle after the 225th beat.
- start pulsed while busy, plus (with TX_SCHED_GUARD_GAP_EN) start during GAP → ignored. The next accepted start comes no earlier than 16 cycles after frame_done.
